// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled start detection, optional parity and sticky error flags,
// feeding a first-word-fall-through receive FIFO with a valid/ready output.
module uart_rx_fifo #(
   parameter int unsigned CLK_HZ     = 27000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          RXD,
   output logic [DATA_BITS-1:0]          O_DATA,
   output logic                          O_VALID,
   input  logic                          O_READY,
   output logic [$clog2(FIFO_DEPTH):0]   O_COUNT,
   input  logic                          ERR_CLR,
   output logic                          O_FRAME_ERR,
   output logic                          O_PARITY_ERR,
   output logic                          O_OVERRUN
);

   localparam int unsigned DIV  = CLK_HZ / BAUD;
   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned CW   = $clog2(DIV + 1);
   localparam int unsigned BW   = $clog2(DATA_BITS + 1);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned NW   = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PAR,
      S_STOP,
      S_BREAK
   } state_t;

   logic [1:0]           sync_q;
   logic                 rx;
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 par_bad_q, par_bad_d;
   logic                 push_c, frame_evt_c, par_evt_c;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]        count_q;
   logic                 pop_c, full_c, wr_en_c, ovr_evt_c;

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge CLK) begin
      if (!RST) sync_q <= 2'b11;
      else      sync_q <= {sync_q[0], RXD};
   end
   assign rx = sync_q[1];

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_bad_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_bad_q <= par_bad_d;
      end
   end

   // Frame sequencing: counter runs to HALF in START, then DIV-1 per bit afterwards
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      par_bad_d   = par_bad_q;
      push_c      = 1'b0;
      frame_evt_c = 1'b0;
      par_evt_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx) begin
               cnt_d   = CW'(1);
               state_d = S_START;
            end
         end
         S_START: begin
            if (cnt_q == CW'(HALF)) begin
               if (!rx) begin
                  cnt_d     = '0;
                  bit_d     = '0;
                  par_bad_d = 1'b0;
                  state_d   = S_DATA;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (cnt_q == CW'(DIV - 1)) begin
               cnt_d   = '0;
               shreg_d = {rx, shreg_q[DATA_BITS-1:1]};
               bit_d   = bit_q + BW'(1);
               if (bit_q == BW'(DATA_BITS - 1))
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_PAR: begin
            if (cnt_q == CW'(DIV - 1)) begin
               cnt_d     = '0;
               par_bad_d = (PARITY == 1) ? ~(^{shreg_q, rx}) : (^{shreg_q, rx});
               state_d   = S_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (cnt_q == CW'(DIV - 1)) begin
               cnt_d = '0;
               if (rx) begin
                  push_c    = ~par_bad_q;
                  par_evt_c = par_bad_q;
                  state_d   = S_IDLE;
               end else begin
                  frame_evt_c = 1'b1;
                  state_d     = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_BREAK: begin
            if (rx) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pop_c     = O_VALID && O_READY;
   assign full_c    = (count_q == NW'(FIFO_DEPTH));
   assign wr_en_c   = push_c && (!full_c || pop_c);
   assign ovr_evt_c = push_c && full_c && !pop_c;

   always_ff @(posedge CLK) begin
      if (wr_en_c) mem[wr_ptr_q] <= shreg_q;
   end

   // Pointers wrap naturally since FIFO_DEPTH is a power of two
   always_ff @(posedge CLK) begin
      if (!RST) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         O_FRAME_ERR  <= 1'b0;
         O_PARITY_ERR <= 1'b0;
         O_OVERRUN    <= 1'b0;
      end else begin
         if (wr_en_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_c)   rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q      <= count_q + NW'(wr_en_c) - NW'(pop_c);
         O_FRAME_ERR  <= frame_evt_c | (O_FRAME_ERR  & ~ERR_CLR);
         O_PARITY_ERR <= par_evt_c   | (O_PARITY_ERR & ~ERR_CLR);
         O_OVERRUN    <= ovr_evt_c   | (O_OVERRUN    & ~ERR_CLR);
      end
   end

   assign O_VALID = (count_q != '0);
   assign O_COUNT = count_q;
   assign O_DATA  = O_VALID ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three instances cover defaults, 7-bit even parity,
// and a 4-deep FIFO for overrun.
module tb_uart_rx_fifo;

   localparam int unsigned DIV_A = 27000000 / 115200;
   localparam int unsigned DIV_F = 1000000 / 50000;

   logic clk = 1'b0;
   logic rst;
   logic err_clr;
   logic rxd_a, rxd_b, rxd_c;
   logic ready_a, ready_b, ready_c;

   logic [7:0] data_a, data_c;
   logic [6:0] data_b;
   logic       valid_a, valid_b, valid_c;
   logic [4:0] count_a, count_b;
   logic [2:0] count_c;
   logic       frame_a, par_a, ovr_a;
   logic       frame_b, par_b, ovr_b;
   logic       frame_c, par_c, ovr_c;

   int unsigned exp_q_a[$], exp_q_b[$], exp_q_c[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          valid_cyc_a = 0;

   always #5 clk = ~clk;

   uart_rx_fifo u_a (
      .CLK(clk), .RST(rst), .RXD(rxd_a),
      .O_DATA(data_a), .O_VALID(valid_a), .O_READY(ready_a), .O_COUNT(count_a),
      .ERR_CLR(err_clr), .O_FRAME_ERR(frame_a), .O_PARITY_ERR(par_a), .O_OVERRUN(ovr_a)
   );

   uart_rx_fifo #(.CLK_HZ(1000000), .BAUD(50000), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(16)) u_b (
      .CLK(clk), .RST(rst), .RXD(rxd_b),
      .O_DATA(data_b), .O_VALID(valid_b), .O_READY(ready_b), .O_COUNT(count_b),
      .ERR_CLR(err_clr), .O_FRAME_ERR(frame_b), .O_PARITY_ERR(par_b), .O_OVERRUN(ovr_b)
   );

   uart_rx_fifo #(.CLK_HZ(1000000), .BAUD(50000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) u_c (
      .CLK(clk), .RST(rst), .RXD(rxd_c),
      .O_DATA(data_c), .O_VALID(valid_c), .O_READY(ready_c), .O_COUNT(count_c),
      .ERR_CLR(err_clr), .O_FRAME_ERR(frame_c), .O_PARITY_ERR(par_c), .O_OVERRUN(ovr_c)
   );

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Stimulus changes 2 time units after the rising edge; monitors sample on the falling edge
   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_rxd(input int sel, input logic v);
      case (sel)
         0:       rxd_a = v;
         1:       rxd_b = v;
         default: rxd_c = v;
      endcase
   endtask

   // par < 0 means no parity bit on the line
   task automatic send(input int sel, input int unsigned data, input int nbits,
                       input int par, input logic stop, input int div);
      set_rxd(sel, 1'b0);
      wait_cyc(div);
      for (int i = 0; i < nbits; i++) begin
         set_rxd(sel, data[i]);
         wait_cyc(div);
      end
      if (par >= 0) begin
         set_rxd(sel, par[0]);
         wait_cyc(div);
      end
      set_rxd(sel, stop);
      wait_cyc(div);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
      wait_cyc(1);
   endtask

   always @(negedge clk) begin
      if (rst && valid_a) valid_cyc_a++;
      if (rst && valid_a && ready_a) begin
         check_eq("a_word_expected", exp_q_a.size() > 0, 1);
         if (exp_q_a.size() > 0) check_eq("a_data", data_a, exp_q_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && valid_b && ready_b) begin
         check_eq("b_word_expected", exp_q_b.size() > 0, 1);
         if (exp_q_b.size() > 0) check_eq("b_data", data_b, exp_q_b.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst && valid_c && ready_c) begin
         check_eq("c_word_expected", exp_q_c.size() > 0, 1);
         if (exp_q_c.size() > 0) check_eq("c_data", data_c, exp_q_c.pop_front());
      end
   end

   initial begin
      int unsigned p;
      rst = 1'b0; err_clr = 1'b0;
      rxd_a = 1'b1; rxd_b = 1'b1; rxd_c = 1'b1;
      ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b0;
      wait_cyc(4);
      check_eq("rst_valid", valid_a, 0);
      check_eq("rst_count", count_a, 0);
      check_eq("rst_data", data_a, 0);
      check_eq("rst_flags", {frame_a, par_a, ovr_a}, 0);
      rst = 1'b1;
      wait_cyc(4);

      // two back-to-back words at default settings
      exp_q_a.push_back(32'h55);
      send(0, 32'h55, 8, -1, 1'b1, DIV_A);
      wait_cyc(2 * DIV_A);
      exp_q_a.push_back(32'hA3);
      send(0, 32'hA3, 8, -1, 1'b1, DIV_A);
      wait_cyc(2 * DIV_A);
      check_eq("t1_drained", exp_q_a.size(), 0);
      check_eq("t1_valid_cycles", valid_cyc_a, 2);
      check_eq("t1_flags", {frame_a, par_a, ovr_a}, 0);
      check_eq("t1_count", count_a, 0);

      // 7-bit even parity: bad parity bit is dropped and flagged, good one is delivered
      p = 32'($countones(32'h41) % 2);
      send(1, 32'h41, 7, int'(p ^ 1), 1'b1, DIV_F);
      wait_cyc(2 * DIV_F);
      check_eq("t2_par_err", par_b, 1);
      check_eq("t2_count", count_b, 0);
      check_eq("t2_frame_err", frame_b, 0);
      pulse_clr();
      check_eq("t2_par_cleared", par_b, 0);
      exp_q_b.push_back(32'h41);
      send(1, 32'h41, 7, int'(p), 1'b1, DIV_F);
      wait_cyc(2 * DIV_F);
      check_eq("t2_drained", exp_q_b.size(), 0);
      check_eq("t2_par_ok", par_b, 0);

      // stop bit low then a held-low line: one frame error, then 0x34 gets through
      send(0, 32'h12, 8, -1, 1'b0, DIV_A);
      wait_cyc(3 * DIV_A);
      check_eq("t3_frame_err", frame_a, 1);
      check_eq("t3_count", count_a, 0);
      pulse_clr();
      wait_cyc(DIV_A);
      check_eq("t3_frame_once", frame_a, 0);
      set_rxd(0, 1'b1);
      wait_cyc(2 * DIV_A);
      exp_q_a.push_back(32'h34);
      send(0, 32'h34, 8, -1, 1'b1, DIV_A);
      wait_cyc(2 * DIV_A);
      check_eq("t3_drained", exp_q_a.size(), 0);
      check_eq("t3_flags", {frame_a, par_a, ovr_a}, 0);

      // overrun on a 4-deep FIFO with the consumer stalled
      for (int v = 1; v <= 5; v++) begin
         if (v <= 4) exp_q_c.push_back(32'(v));
         send(2, 32'(v), 8, -1, 1'b1, DIV_F);
         wait_cyc(DIV_F);
      end
      check_eq("t4_count_full", count_c, 4);
      check_eq("t4_overrun", ovr_c, 1);
      check_eq("t4_head", data_c, 1);
      ready_c = 1'b1;
      wait_cyc(10);
      check_eq("t4_drained", exp_q_c.size(), 0);
      check_eq("t4_count_empty", count_c, 0);
      pulse_clr();
      check_eq("t4_ovr_cleared", ovr_c, 0);

      // short low glitch is a false start
      set_rxd(0, 1'b0);
      wait_cyc(50);
      set_rxd(0, 1'b1);
      wait_cyc(2 * DIV_A);
      check_eq("t5_count", count_a, 0);
      check_eq("t5_flags", {frame_a, par_a, ovr_a}, 0);

      // reset in the middle of 0x7E, then 0x81 in full
      set_rxd(0, 1'b0);
      wait_cyc(DIV_A);
      for (int i = 0; i < 4; i++) begin
         set_rxd(0, (i == 0) ? 1'b0 : 1'b1);
         wait_cyc(DIV_A);
      end
      rst = 1'b0;
      set_rxd(0, 1'b1);
      wait_cyc(3);
      rst = 1'b1;
      wait_cyc(DIV_A);
      check_eq("t6_count_after_rst", count_a, 0);
      exp_q_a.push_back(32'h81);
      send(0, 32'h81, 8, -1, 1'b1, DIV_A);
      wait_cyc(2 * DIV_A);
      check_eq("t6_drained", exp_q_a.size(), 0);
      check_eq("t6_flags", {frame_a, par_a, ovr_a}, 0);
      check_eq("t6_count", count_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a built-in receive FIFO, the next generation of our serial receive path. It oversamples an asynchronous RXD line at a divisor derived from clock frequency and baud rate, supports configurable data width and optional parity, and detects framing, parity and overrun errors. Received words are buffered in a first-word-fall-through FIFO with a valid/ready output handshake, so a downstream consumer (e.g. a COBS decoder or command parser) can stall without losing data.

## Interface

- CLK_HZ, 27000000, system clock frequency in Hz
- BAUD, 115200, line baud rate; DIV = CLK_HZ / BAUD (integer, truncated), HALF = DIV / 2
- DATA_BITS, 8, data bits per frame, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-low reset
- RXD  in  1  asynchronous serial input, idle high
- O_DATA  out  DATA_BITS  head-of-FIFO word, LSB = first received bit
- O_VALID  out  1  FIFO not empty
- O_READY  in  1  consumer accepts O_DATA this cycle
- O_COUNT  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- ERR_CLR  in  1  clears all sticky error flags
- O_FRAME_ERR  out  1  sticky: stop bit sampled low
- O_PARITY_ERR  out  1  sticky: parity mismatch
- O_OVERRUN  out  1  sticky: word received while FIFO full and not popped

## Operation

- RXD passes through a 2-FF synchronizer (initialised high); all decisions use the synchronised signal `rx`.
- State machine states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE: on `rx`==0, load the counter with 1 and go to START.
- START: when the counter reaches HALF, re-sample `rx`. If it is 0, clear the counter and bit index and go to DATA. If it is 1, treat it as a false start and return to IDLE with no flags raised.
- DATA: sample `rx` every DIV cycles and shift it in LSB-first. After DATA_BITS samples, go to PAR if PARITY!=0, else go to STOP.
- PAR: sample after DIV cycles. Mismatch against XOR of the data (odd: XOR of data and parity bit must be 1; even: it must be 0) marks the frame bad-parity.
- STOP: sample after DIV cycles.
  - Stop==1 with good parity: push the word, go to IDLE.
  - Stop==1 with bad parity: set O_PARITY_ERR, discard the word, go to IDLE.
  - Stop==0: set O_FRAME_ERR, discard the word, go to BREAK.
- BREAK: wait for `rx`==1, then go to IDLE. A held-low line yields exactly one frame error.
- FIFO behaviour:
  - Pop when O_VALID && O_READY.
  - Push when full with no pop in the same cycle: word dropped, O_OVERRUN set.
  - Push when full with a pop in the same cycle: push accepted, count unchanged.
  - Push when empty with O_READY high: word still written first; it becomes visible on the next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- O_COUNT = pushes − pops. Width is sufficient for value FIFO_DEPTH.
- Sticky error flags hold until ERR_CLR=1. If ERR_CLR and a new error event occur in the same cycle, the event wins and the flag stays 1.

## Timing

- Reset values:
  - Outputs: O_VALID=0, O_COUNT=0, all error flags 0, O_DATA=0.
  - Internal: state IDLE, FIFO pointers 0, synchronizer 1.
- Reset mid-frame aborts the frame. Partial data is never pushed.
- Start-edge detection latency is 2 cycles (synchronizer).
- Bit sampling points fall at HALF + k·DIV cycles after `rx` first observed low, k = 1..(frame bits).
- Push occurs in the cycle the stop bit is sampled. O_VALID rises on the following cycle, and O_DATA is valid in that same cycle.
- At defaults (DIV=234, HALF=117), push lands about 2 + 117 + 9·234 = 2225 cycles after the RXD falling edge.
- Next start bit is accepted from the cycle after the STOP sample. No extra idle time is required beyond the stop half-bit.
- O_DATA is combinational from the FIFO head register/RAM output and remains stable while O_VALID && !O_READY.

## Test plan

- Defaults, send 0x55 then 0xA3 at 115200 with O_READY=1: O_DATA shows 0x55 then 0xA3, one O_VALID cycle each, no error flags.
- PARITY=2, DATA_BITS=7, send 0x41 with wrong parity bit: O_PARITY_ERR=1, O_COUNT stays 0. Then pulse ERR_CLR: flag returns to 0.
- Stop bit forced low on 0x12, RXD held low for 3 bit times, then 0x34 sent: O_FRAME_ERR=1 exactly once, only 0x34 appears in the FIFO.
- O_READY=0, FIFO_DEPTH=4, send 0x01..0x05: O_COUNT=4, O_OVERRUN=1. Draining yields 0x01..0x04.
- RXD low glitch of 50 cycles (< HALF): no state beyond START, no push, no flags.
- Reset asserted mid-byte of 0x7E, then full 0x81 sent: only 0x81 received, all flags 0.
